jtsdram_bank_chk: RTL

// Per-bank responder to the test sequencer's rd_start/baN_done handshake. On each

---
 rtl/jtsdram_pkg.sv | 24 ++
 rtl/jtsdram_bank_chk_if.sv | 40 ++++
 rtl/jtsdram_bank_chk.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the per-bank SDRAM checker and the sequencer-side model.
package jtsdram_pkg;

    localparam int KEY_W   = 5;
    localparam int DATA_W  = 16;
    localparam int CNTX_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Pattern written at (and expected back from) each address of a sweep.
    function automatic logic [DATA_W-1:0] exp(
        input logic [DATA_W-1:0] data_ref,
        input logic [KEY_W-1:0]  key,
        input logic [CNTX_W-1:0] cnt
    );
        return data_ref ^ {key, 11'd0} ^ {5'd0, cnt};
    endfunction

endpackage

// File: rtl/jtsdram_bank_chk_if.sv
// Sequencer handshake plus SDRAM bank port seen by one bank checker.
interface jtsdram_bank_chk_if #(
    parameter int AW   = 22,
    parameter int ERRW = 8
);
    logic            start;
    logic [4:0]      key;
    logic [15:0]     data_ref;
    logic            we;
    logic            slow;
    logic            done;
    logic [AW-1:0]   sd_addr;
    logic            sd_rd;
    logic            sd_wr;
    logic [15:0]     sd_din;
    logic            sd_ack;
    logic            sd_dok;
    logic [15:0]     sd_dout;
    logic            err;
    logic [ERRW-1:0] err_cnt;
    logic [AW-1:0]   bad_addr;

    // Bank checker side: masters the SDRAM port, answers the sequencer.
    modport master (
        input  start, key, data_ref, we, slow,
        output done,
        output sd_addr, sd_rd, sd_wr, sd_din,
        input  sd_ack, sd_dok, sd_dout,
        output err, err_cnt, bad_addr
    );

    // Environment side: sequencer and SDRAM controller bank port.
    modport slave (
        output start, key, data_ref, we, slow,
        input  done,
        input  sd_addr, sd_rd, sd_wr, sd_din,
        output sd_ack, sd_dok, sd_dout,
        input  err, err_cnt, bad_addr
    );
endinterface

// File: rtl/jtsdram_bank_chk.sv
// One bank's write/read-check sweep engine with watchdog and sticky error log.
module jtsdram_bank_chk #(
    parameter int AW    = 22,
    parameter int LEN_W = 8,
    parameter int GAP   = 7,
    parameter int TMO_W = 6,
    parameter int ERRW  = 8
) (
    input logic                clk,
    input logic                rst_n,
    jtsdram_bank_chk_if.master bus
);
    import jtsdram_pkg::*;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

    state_t              r_state;
    state_t              w_next;
    logic [KEY_W-1:0]    r_key;
    logic [DATA_W-1:0]   r_ref;
    logic                r_we;
    logic                r_slow;
    logic [LEN_W-1:0]    r_cnt;
    logic [GW-1:0]       r_gap;
    logic [TMO_W-1:0]    r_wdog;
    logic                r_err;
    logic [ERRW-1:0]     r_errCnt;
    logic [AW-1:0]       r_badAddr;

    logic [CNTX_W-1:0]   w_cnt11;
    logic [AW-1:0]       w_addr;
    logic [DATA_W-1:0]   w_exp;
    logic                w_last;
    logic                w_accDone;
    logic                w_tmo;
    logic                w_step;
    logic                w_err;

    assign w_cnt11 = CNTX_W'(r_cnt);
    assign w_addr  = (AW'(r_key) << (AW - KEY_W)) | AW'(r_cnt);
    assign w_exp   = exp(r_ref, r_key, w_cnt11);
    assign w_last  = (r_cnt == {LEN_W{1'b1}});
    assign w_err   = w_tmo || (w_accDone && !r_we && (bus.sd_dout != w_exp));

    // State register; start and async reset dominate everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: an access finishes on dok (possibly together with ack) or on watchdog expiry.
    always_comb begin
        w_next    = r_state;
        w_accDone = 1'b0;
        w_tmo     = 1'b0;
        w_step    = 1'b0;
        if (bus.start) begin
            w_next = ST_REQ;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_IDLE;
                ST_REQ: begin
                    if (bus.sd_ack && bus.sd_dok) begin
                        w_accDone = 1'b1;
                    end else if (bus.sd_ack) begin
                        w_next = ST_WAIT;
                    end else if (r_wdog >= TMO_LAST) begin
                        w_tmo = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.sd_dok) begin
                        w_accDone = 1'b1;
                    end else if (r_wdog >= TMO_LAST) begin
                        w_tmo = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        w_next = ST_REQ;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
            w_step = w_accDone || w_tmo;
            // Leaving REQ directly needs a GAP cycle so the request line drops between accesses.
            if (w_step) begin
                if (w_last) begin
                    w_next = ST_IDLE;
                end else if (r_slow || (r_state == ST_REQ)) begin
                    w_next = ST_GAP;
                end else begin
                    w_next = ST_REQ;
                end
            end
        end
    end

    // Outputs are decoded from state and registers only, so reset forces them immediately.
    always_comb begin
        bus.done     = (r_state == ST_IDLE);
        bus.sd_rd    = (r_state == ST_REQ) && !r_we;
        bus.sd_wr    = (r_state == ST_REQ) && r_we;
        bus.sd_din   = ((r_state == ST_REQ) && r_we) ? w_exp : '0;
        bus.sd_addr  = w_addr;
        bus.err      = r_err;
        bus.err_cnt  = r_errCnt;
        bus.bad_addr = r_badAddr;
    end

    // Sweep datapath: latched parameters, address counter, gap/watchdog timers and error log.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_ref     <= '0;
            r_we      <= 1'b0;
            r_slow    <= 1'b0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
            r_errCnt  <= '0;
            r_badAddr <= '0;
        end else if (bus.start) begin
            r_key  <= bus.key;
            r_ref  <= bus.data_ref;
            r_we   <= bus.we;
            r_slow <= bus.slow;
            r_cnt  <= '0;
            r_gap  <= '0;
            r_wdog <= '0;
        end else begin
            if (w_step) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_wdog <= '0;
                r_gap  <= r_slow ? GAP_LOAD : '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_wdog <= r_wdog + TMO_W'(1);
            end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - GW'(1);
            end
            if (w_err) begin
                r_err     <= 1'b1;
                r_badAddr <= w_addr;
                if (r_errCnt != {ERRW{1'b1}}) begin
                    r_errCnt <= r_errCnt + ERRW'(1);
                end
            end
        end
    end

endmodule
